mem_mmio_resp: RTL and testbench
================================

MEM_MMIO_RESP -- requirements
Module: mem_mmio_resp

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit data RAM words (power of two).
REQ-002 Parameter FIFO_DEPTH, default 4, console TX FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Adr  input  32  byte address from processor.
REQ-006 WriteData  input  32  store data from processor.
REQ-007 MemWrite  input  1  write strobe, sampled on rising clk.
REQ-008 ReadData  output  32  load data for Adr.
REQ-009 tx_valid  output  1  console byte available.
REQ-010 tx_data  output  8  console byte at FIFO head.
REQ-011 tx_ready  input  1  console sink accepts byte when tx_valid & tx_ready.
REQ-012 done  output  1  program has written RESULT.
REQ-013 result  output  32  last value written to RESULT.

Function
REQ-014 Address map: 0x0000_0000..(4*RAM_WORDS-4) RAM; 0x8000_0000 CYCLE (RO); 0x8000_0004 RESULT (RW); 0x8000_0008 TXDATA (WO); 0x8000_000C STATUS (RO except W1C bit2); all else unmapped.
REQ-015 Decode uses Adr[31:2] only; Adr[1:0] ignored; RAM index Adr[log2(RAM_WORDS)+1:2].
REQ-016 ReadData combinational from Adr in same cycle (zero-latency read) for RAM, CYCLE, RESULT, STATUS; TXDATA and unmapped read 0.
REQ-017 RAM write on rising clk when MemWrite=1 and Adr in RAM region; read-during-write same address returns old data until the edge.
REQ-018 CYCLE increments by 1 every clk after reset release, wraps 0xFFFF_FFFF->0.
REQ-019 Write to RESULT: result<=WriteData, done<=1 next cycle; done sticky until reset; later writes update result.
REQ-020 Write to TXDATA pushes WriteData[7:0] into FIFO when not full; when full, byte dropped, overflow<=1 (sticky).
REQ-021 Pop when tx_valid & tx_ready; tx_valid = FIFO not empty; tx_data = head entry, stable while tx_valid & !tx_ready.
REQ-022 Simultaneous push and pop when full: both accepted, count unchanged, no overflow.
REQ-023 Simultaneous push and pop at count 1: push accepted, head advances, count stays 1.
REQ-024 Push to empty FIFO: tx_valid asserts the following cycle (registered FIFO).
REQ-025 STATUS read: bit0 full, bit1 empty, bit2 overflow, bit3 done, bits[6:4] count (zero-extended/truncated to 3 bits), others 0.
REQ-026 Write to STATUS with WriteData[2]=1 clears overflow; coincident overflow event wins (stays 1).
REQ-027 Writes to CYCLE and unmapped addresses ignored; no state change.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-029 On reset assertion, immediately: CYCLE=0, result=0, done=0, overflow=0, FIFO pointers/count=0, tx_valid=0, tx_data=0.
REQ-030 RAM contents not reset; reset mid-transfer discards FIFO contents, no further tx_valid until new push.
REQ-031 MemWrite ignored while reset asserted.

Structure
REQ-032 Shared package holds address constants (ADR_RAM_BASE, ADR_CYCLE, ADR_RESULT, ADR_TXDATA, ADR_STATUS) and STATUS bit-index constants.
REQ-033 One sub-module tx_fifo (parameterised depth/width, push/pop/full/empty/count); decode, RAM and registers in mem_mmio_resp.

Verification
REQ-034 Write 0xDEADBEEF to 0x10, then Adr=0x10 -> ReadData=0xDEADBEEF same cycle; Adr=0x8000_0010 -> ReadData=0.
REQ-035 Release reset, wait 100 clk, read 0x8000_0000 -> value 100 (+/- edge alignment documented by bench); force near 0xFFFF_FFFF -> wraps to 0.
REQ-036 Push 'A','B','C','D','E' with tx_ready=0 -> STATUS=0x0000_0045 (count 4, overflow, full); drain -> A,B,C,D in order, then tx_valid=0.
REQ-037 FIFO full, tx_ready=1, push 'X' same cycle -> no overflow, count 4, 'X' emerges last.
REQ-038 Write 1 to RESULT -> done=1 next cycle, result=0x0000_0001; assert reset mid-drain -> done=0, tx_valid=0 immediately.
REQ-039 Write STATUS with bit2=1 after overflow -> STATUS bit2=0; same cycle as overflowing push -> bit2 stays 1.

Source files
------------

// File: rtl/mem_mmio_resp_pkg.sv
// Shared definitions for the memory / MMIO responder.
// Holds the MMIO address map, the STATUS register bit layout, the
// address-region type used by the decoder and a word-address compare helper.
package mem_mmio_resp_pkg;

  // Address map (byte addresses; decode only looks at bits [31:2])
  localparam logic [31:0] ADR_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] ADR_CYCLE    = 32'h8000_0000;
  localparam logic [31:0] ADR_RESULT   = 32'h8000_0004;
  localparam logic [31:0] ADR_TXDATA   = 32'h8000_0008;
  localparam logic [31:0] ADR_STATUS   = 32'h8000_000C;

  // STATUS register bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_DONE      = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 3;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_CYCLE,
    RGN_RESULT,
    RGN_TXDATA,
    RGN_STATUS,
    RGN_NONE
  } region_e;

  // True when two byte addresses refer to the same 32-bit word.
  function automatic logic word_match(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/mem_mmio_resp_tx_fifo.sv
// tx_fifo: registered synchronous FIFO feeding the console byte sink.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   push, din        write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   dout             head entry, 0 while empty
//   full, empty      occupancy flags
//   count            number of stored entries, 0..DEPTH
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Forcing 0 while empty keeps the output at its reset value even though
  // the storage array itself is never cleared.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only pointers and count define
  // validity, which keeps the array mappable to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_mmio_resp.sv
// mem_mmio_resp: data RAM plus MMIO registers answering a single-cycle
// processor bus (zero-latency reads, writes on the rising clock edge).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   Adr, WriteData     byte address and store data
//   MemWrite           write strobe
//   ReadData           combinational load data for Adr
//   tx_valid, tx_data  console byte stream out of the TX FIFO
//   tx_ready           console sink handshake
//   done, result       RESULT register has been written / its last value
module mem_mmio_resp
  import mem_mmio_resp_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] result
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  region_e            rgn;
  logic               we;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        ram [RAM_WORDS];
  logic [31:0]        cycle_q;
  logic               overflow;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ST_COUNT_W-1:0] count_st;
  logic [31:0]        status_word;
  logic [1:0]         unused_adr_lsbs;

  // Byte lane bits play no part in word-wide decode.
  assign unused_adr_lsbs = Adr[1:0];

  // NOTE: always_comb assigns every output a default first so no path can
  // leave a value held, which would otherwise infer a latch.
  always_comb begin
    rgn = RGN_NONE;
    if (Adr[31:RAM_AW+2] == ADR_RAM_BASE[31:RAM_AW+2]) rgn = RGN_RAM;
    else if (word_match(Adr, ADR_CYCLE))               rgn = RGN_CYCLE;
    else if (word_match(Adr, ADR_RESULT))              rgn = RGN_RESULT;
    else if (word_match(Adr, ADR_TXDATA))              rgn = RGN_TXDATA;
    else if (word_match(Adr, ADR_STATUS))              rgn = RGN_STATUS;
  end

  assign ram_idx = Adr[RAM_AW+1:2];
  // The RAM has no reset branch, so its writes are gated explicitly.
  assign we      = MemWrite & ~reset;

  always_ff @(posedge clk) begin
    if (we && rgn == RGN_RAM) ram[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      done   <= 1'b0;
    end else if (we && rgn == RGN_RESULT) begin
      result <= WriteData;
      done   <= 1'b1;
    end
  end

  assign fifo_push = we && rgn == RGN_TXDATA;
  assign fifo_pop  = tx_valid & tx_ready;

  // A dropped byte sets overflow; the set outranks a coincident W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (we && rgn == RGN_STATUS && WriteData[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign count_st = ST_COUNT_W'(fifo_count);

  always_comb begin
    status_word = '0;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_OVERFLOW] = overflow;
    status_word[ST_DONE]     = done;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = count_st;
  end

  always_comb begin
    ReadData = '0;
    unique case (rgn)
      RGN_RAM:    ReadData = ram[ram_idx];
      RGN_CYCLE:  ReadData = cycle_q;
      RGN_RESULT: ReadData = result;
      RGN_STATUS: ReadData = status_word;
      default:    ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_mmio_resp.sv
// Self-checking bench for mem_mmio_resp: a vector table for the RAM/register
// map plus hand-written sequences for the counter, FIFO and reset corners.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_mmio_resp;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_RESULT = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  logic        clk;
  logic        reset;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mem_mmio_resp #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Adr       (Adr),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Adr = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk);
    #1 MemWrite = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    Adr = a; MemWrite = 1'b0;
    #1 check(name, ReadData, exp);
  endtask

  // Pop one byte with tx_ready held for a single cycle.
  task automatic drain_one(input string name, input logic [7:0] exp);
    @(negedge clk);
    tx_ready = 1'b1;
    #1 check({name, "_valid"}, tx_valid, 1);
    check({name, "_data"}, tx_data, exp);
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; tx_ready = 1'b0;
    Adr = A_CYCLE; WriteData = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cycle", ReadData, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);

    // CYCLE: released on a falling edge, so the 100th rising edge yields 100.
    @(negedge clk) reset = 1'b0;
    repeat (100) @(posedge clk);
    #1 Adr = A_CYCLE;
    #1 check("cycle_100", ReadData, 100);

    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 check("cycle_forced", ReadData, 32'hFFFF_FFFF);
    release dut.cycle_q;
    @(posedge clk);
    #1 check("cycle_wrap", ReadData, 0);
    bus_write(A_CYCLE, 32'd5);
    check("cycle_write_ignored", ReadData, 1);

    // Memory map vectors
    vecs[0]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h0000_0013, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{32'h8000_0010, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{32'h0000_00FC, 1'b1, 32'h1234_5678, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_00FC, 1'b0, 32'h0,         1'b1, 32'h1234_5678};
    vecs[7]  = '{32'h0000_0100, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{32'h0000_0010, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{32'h0000_0010, 1'b0, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[10] = '{32'h0000_0100, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    vecs[11] = '{32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{A_TXDATA,      1'b0, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{A_RESULT,      1'b0, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{A_STATUS,      1'b0, 32'h0,         1'b1, 32'h0000_0002};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      Adr = vecs[i].adr; WriteData = vecs[i].wdata; MemWrite = vecs[i].we;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), ReadData, vecs[i].exp);
      @(posedge clk);
      #1 MemWrite = 1'b0;
    end
    check("unmapped_no_done", done, 0);

    // FIFO overflow: five pushes into four slots with the sink stalled
    check("fifo_pre_valid", tx_valid, 0);
    bus_write(A_TXDATA, 32'h41);
    check("fifo_valid_after_push", tx_valid, 1);
    check("fifo_head_A", tx_data, 8'h41);
    for (int c = 8'h42; c <= 8'h45; c++) bus_write(A_TXDATA, 32'(c));
    read_check("status_full_ovf", A_STATUS, 32'h0000_0045);
    check("fifo_head_stable", tx_data, 8'h41);
    for (int c = 8'h41; c <= 8'h44; c++) drain_one($sformatf("drain_%c", c), 8'(c));
    #1 check("fifo_empty_after_drain", tx_valid, 0);
    read_check("status_empty_ovf", A_STATUS, 32'h0000_0006);

    // Overflow is only cleared by writing a 1 to bit 2
    bus_write(A_STATUS, 32'hFFFF_FFFB);
    read_check("status_w0_keeps_ovf", A_STATUS, 32'h0000_0006);
    bus_write(A_STATUS, 32'h0000_0004);
    read_check("status_w1c", A_STATUS, 32'h0000_0002);

    // Push while full and popping: accepted, no overflow, 'X' last
    for (int c = 8'h46; c <= 8'h49; c++) bus_write(A_TXDATA, 32'(c));
    read_check("status_full", A_STATUS, 32'h0000_0041);
    @(negedge clk);
    Adr = A_TXDATA; WriteData = 32'h58; MemWrite = 1'b1; tx_ready = 1'b1;
    #1 check("full_pushpop_head", tx_data, 8'h46);
    @(posedge clk);
    #1 MemWrite = 1'b0; tx_ready = 1'b0;
    read_check("status_full_pushpop", A_STATUS, 32'h0000_0041);
    drain_one("drain_G", 8'h47);
    drain_one("drain_H", 8'h48);
    drain_one("drain_I", 8'h49);
    drain_one("drain_X", 8'h58);
    #1 check("fifo_empty_after_X", tx_valid, 0);

    // Push and pop at count 1
    bus_write(A_TXDATA, 32'h59);
    @(negedge clk);
    Adr = A_TXDATA; WriteData = 32'h5A; MemWrite = 1'b1; tx_ready = 1'b1;
    #1 check("one_pushpop_head", tx_data, 8'h59);
    @(posedge clk);
    #1 MemWrite = 1'b0; tx_ready = 1'b0;
    read_check("status_count1", A_STATUS, 32'h0000_0010);
    drain_one("drain_Z", 8'h5A);

    // RESULT / done
    @(negedge clk);
    Adr = A_RESULT; WriteData = 32'h1; MemWrite = 1'b1;
    #1 check("done_before_edge", done, 0);
    @(posedge clk);
    #1 MemWrite = 1'b0;
    check("done_set", done, 1);
    check("result_1", result, 32'h1);
    read_check("result_read", A_RESULT, 32'h1);
    read_check("status_done", A_STATUS, 32'h0000_000A);
    bus_write(A_RESULT, 32'hA5A5_0000);
    check("result_update", result, 32'hA5A5_0000);
    check("done_sticky", done, 1);

    // Reset mid-drain, with a RAM write attempted while reset is held
    bus_write(A_TXDATA, 32'h50);
    bus_write(A_TXDATA, 32'h51);
    drain_one("drain_P", 8'h50);
    @(negedge clk);
    tx_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_tx_data", tx_data, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    Adr = 32'h10; WriteData = 32'h55; MemWrite = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("post_rst_no_valid", tx_valid, 0);
    tx_ready = 1'b0;
    read_check("ram_kept_over_reset", 32'h10, 32'hCAFE_F00D);
    read_check("status_after_reset", A_STATUS, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
